uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//   Serialises one payload per frame: start bit, DATA_BITS data bits (LSB
//   first), optional even/odd parity bit, STOP_BITS stop bits. Every bit lasts
//   CLKS_PER_BIT clocks. All outputs are registered.
//
//   Optional feature macro: UART_TX_BREAK_EN
//     Adds i_break_req and a BREAK state that holds the line low while the
//     request is high. Only entered from IDLE; wins over i_tx_valid.
//
// Ports
//   i_clk          clock, all logic on posedge
//   i_reset        synchronous active-high reset
//   i_tx_data      payload, latched on acceptance
//   i_tx_valid     payload request
//   o_tx_ready     high only in IDLE
//   i_parity_mode  00 none, 01 even, 10 odd, 11 none; latched on acceptance
//   i_break_req    (UART_TX_BREAK_EN only) hold line in break
//   o_tx           serial line, idle high
//   o_tx_busy      high while a frame or break is on the line
//   o_tx_done      one-cycle pulse when the stop bit(s) complete
// -----------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  input  logic [1:0]           i_parity_mode,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_break_req,
`endif
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_clk_cnt;   // clocks elapsed in current bit
  logic [IDX_W-1:0]       r_bit_idx;   // data bit index, reused as stop-bit index
  logic [DATA_BITS-1:0]   r_shift;     // remaining payload, bit 0 is on the line
  logic                   r_par_en;
  logic                   r_par_bit;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ready;

  logic w_bit_end;
  logic w_break;
  logic w_par_en;
  logic w_par_bit;

  assign w_bit_end = (r_clk_cnt == CNT_LAST);
  assign w_par_en  = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
  // Even parity is the XOR of the data; odd parity is its inverse.
  assign w_par_bit = (^i_tx_data) ^ (i_parity_mode == 2'b10);

`ifdef UART_TX_BREAK_EN
  assign w_break = i_break_req;
`else
  assign w_break = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (w_break) begin
`ifdef UART_TX_BREAK_EN
            r_state <= S_BREAK;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
`endif
          end else if (i_tx_valid) begin
            r_shift   <= i_tx_data;
            r_par_en  <= w_par_en;
            r_par_bit <= w_par_bit;
            r_state   <= S_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == DATA_LAST) begin
              r_bit_idx <= '0;
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];   // next bit, ahead of the shift
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= S_STOP;
            r_tx      <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == STOP_LAST) begin
              // Done pulse coincides with the single IDLE cycle, so a held
              // tx_valid restarts with exactly one high cycle in between.
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_ready   <= 1'b1;
              r_tx      <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          if (!w_break) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx       = r_tx;
  assign o_tx_busy  = r_busy;
  assign o_tx_done  = r_done;
  assign o_tx_ready = r_ready;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  localparam int DB  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    parity_mode;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;
`ifdef UART_TX_BREAK_EN
  logic          break_req;
`endif

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .i_parity_mode (parity_mode),
`ifdef UART_TX_BREAK_EN
    .i_break_req   (break_req),
`endif
    .o_tx          (tx),
    .o_tx_busy     (tx_busy),
    .o_tx_done     (tx_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the frame as a list of line levels, one per bit period.
  task automatic model_bits(input logic [DB-1:0] d, input logic [1:0] m,
                            output logic [15:0] bits, output int nbits);
    bits = '0;
    nbits = 0;
    bits[nbits++] = 1'b0;
    for (int i = 0; i < DB; i++) bits[nbits++] = d[i];
    if (m == 2'd1) bits[nbits++] = ($countones(d) % 2 == 1);
    if (m == 2'd2) bits[nbits++] = ($countones(d) % 2 == 0);
    for (int i = 0; i < SB; i++) bits[nbits++] = 1'b1;
  endtask

  // Wait for ready, present the payload, return at the negedge of the
  // first start-bit cycle.
  task automatic start_frame(input logic [DB-1:0] d, input logic [1:0] m, input bit hold);
    int w;
    @(negedge clk);
    tx_data = d; parity_mode = m; tx_valid = 1'b1;
    w = 0;
    while (!tx_ready && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) chk("ready_timeout", 0, 1);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Entered at the negedge of start-bit cycle 0; returns at the negedge of
  // the done cycle. Inputs are scrambled during the frame.
  task automatic run_frame(input logic [DB-1:0] d, input logic [1:0] m,
                           output int len, output logic [255:0] trace);
    logic [15:0] bits;
    int nbits, k, exp_len;
    bit ok_tx, ok_bsy;
    model_bits(d, m, bits, nbits);
    exp_len = nbits * CPB;
    ok_tx = 1; ok_bsy = 1; k = 0; trace = '1;
    while (!tx_done && k < 200) begin
      trace[k] = tx;
      if (k >= exp_len || tx !== bits[k / CPB]) ok_tx = 0;
      if (tx_busy !== 1'b1 || tx_ready !== 1'b0) ok_bsy = 0;
      tx_data = DB'($urandom);
      parity_mode = 2'($urandom);
      @(negedge clk);
      k++;
    end
    len = k;
    chk("frame_len", len, exp_len);
    chk("frame_bits", 32'(ok_tx), 1);
    chk("busy_ready_in_frame", 32'(ok_bsy), 1);
    chk("done_cycle_tx_busy_ready", {tx, tx_busy, tx_ready}, 3'b101);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic [1:0]    mode;
    int            exp_par;   // 2 = no parity bit
    int            exp_len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int len;
    logic [255:0] tr;
    bit ok;

    vecs[0] = '{8'h55, 2'd0, 2, 40};
    vecs[1] = '{8'h07, 2'd1, 1, 44};
    vecs[2] = '{8'h07, 2'd2, 0, 44};
    vecs[3] = '{8'h00, 2'd2, 1, 44};
    vecs[4] = '{8'hFF, 2'd1, 0, 44};
    vecs[5] = '{8'h80, 2'd3, 2, 40};

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; parity_mode = '0;
`ifdef UART_TX_BREAK_EN
    break_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_state", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);

    // Table vectors
    foreach (vecs[i]) begin
      start_frame(vecs[i].data, vecs[i].mode, 0);
      run_frame(vecs[i].data, vecs[i].mode, len, tr);
      chk($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
      if (vecs[i].exp_par != 2)
        chk($sformatf("vec%0d_parity", i), 32'(tr[(1 + DB) * CPB + CPB / 2]), vecs[i].exp_par);
      @(negedge clk);
      chk($sformatf("vec%0d_done_single", i), 32'(tx_done), 0);
    end

    // Back-to-back with tx_valid held high
    start_frame(8'hA3, 2'd0, 1);
    run_frame(8'hA3, 2'd0, len, tr);
    tx_data = 8'h3C; parity_mode = 2'd0;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_second_start", {tx, tx_busy, tx_done}, 3'b010);
    run_frame(8'h3C, 2'd0, len, tr);

    // Randomized frames
    for (int n = 0; n < 10; n++) begin
      logic [DB-1:0] d;
      logic [1:0] m;
      d = DB'($urandom);
      m = 2'($urandom_range(0, 3));
      start_frame(d, m, 0);
      run_frame(d, m, len, tr);
    end

    // Reset mid-frame
    start_frame(8'hFF, 2'd0, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midframe_reset", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    ok = 1;
    repeat (60) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx !== 1'b1) ok = 0;
    end
    chk("no_done_after_reset", 32'(ok), 1);
    start_frame(8'h5A, 2'd1, 0);
    run_frame(8'h5A, 2'd1, len, tr);

`ifdef UART_TX_BREAK_EN
    // Break beats tx_valid; line low for exactly the request duration
    @(negedge clk);
    break_req = 1'b1; tx_valid = 1'b1; tx_data = 8'hC3; parity_mode = 2'd0;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) ok = 0;
    end
    break_req = 1'b0;
    chk("break_low_20", 32'(ok), 1);
    @(negedge clk);
    chk("break_exit_idle", {tx, tx_ready, tx_busy}, 3'b110);
    @(negedge clk);
    tx_valid = 1'b0;
    run_frame(8'hC3, 2'd0, len, tr);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
